tx_burst_gen: RTL and testbench



---
 rtl/tx_burst_pkg.sv | 21 ++
 rtl/tx_phase_timer.sv | 48 ++++
 rtl/tx_burst_gen.sv | 117 +++++++++++
 tb/tb_tx_burst_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_burst_pkg.sv
// Shared types and constants for the transmit-burst generator.
package tx_burst_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        DRIVE = 4'b0010,
        BLANK = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    localparam int unsigned DEF_HALF_PERIOD = 1250;
    localparam int unsigned DEF_DEAD_CYC    = 10;
    localparam int unsigned DEF_PULSE_NUM   = 8;
    localparam int unsigned DEF_BLANK_CYC   = 5000;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_phase_timer.sv
// Phase counter over one full drive cycle with registered tx_p/tx_n decode.
module tx_phase_timer
    import tx_burst_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int unsigned DEAD_CYC    = DEF_DEAD_CYC
) (
    input  logic clk_100,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic tx_p,
    output logic tx_n,
    output logic wrap_c
);

    localparam int unsigned PERIOD = 2 * HALF_PERIOD;
    localparam int unsigned PW     = cnt_w(PERIOD);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    logic          drive_c;

    assign wrap_c  = (phase == PW'(PERIOD - 1));
    assign drive_c = start | run;

    // Start and wrap both land on count 0; neither start nor run clears the timer.
    always_comb begin
        phase_nxt = '0;
        if (run && !wrap_c) begin
            phase_nxt = phase + PW'(1);
        end
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            phase <= '0;
            tx_p  <= 1'b0;
            tx_n  <= 1'b0;
        end else begin
            phase <= phase_nxt;
            tx_p  <= drive_c && (phase_nxt < PW'(HALF_PERIOD - DEAD_CYC));
            tx_n  <= drive_c && (phase_nxt >= PW'(HALF_PERIOD))
                             && (phase_nxt < PW'(PERIOD - DEAD_CYC));
        end
    end

endmodule

// File: rtl/tx_burst_gen.sv
// Transmit-burst generator: complementary drive burst, ring-down blanking, then overTx handshake.
module tx_burst_gen
    import tx_burst_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int unsigned DEAD_CYC    = DEF_DEAD_CYC,
    parameter int unsigned PULSE_NUM   = DEF_PULSE_NUM,
    parameter int unsigned BLANK_CYC   = DEF_BLANK_CYC
) (
    input  logic                               clk_100,
    input  logic                               rst_n,
    input  logic                               enTx,
    output logic                               overTx,
    output logic                               tx_p,
    output logic                               tx_n,
    output logic                               busy,
    output logic [$clog2(PULSE_NUM+1)-1:0]     pulse_idx
);

    localparam int unsigned IDX_W = $clog2(PULSE_NUM + 1);
    localparam int unsigned BW    = cnt_w(BLANK_CYC);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] pulse_nxt;
    logic [BW-1:0]    blank_cnt;
    logic [BW-1:0]    blank_nxt;
    logic             timer_start;
    logic             timer_run;
    logic             wrap_c;
    logic             last_pulse_c;

    assign last_pulse_c = (pulse_idx == IDX_W'(PULSE_NUM - 1));

    tx_phase_timer #(
        .HALF_PERIOD (HALF_PERIOD),
        .DEAD_CYC    (DEAD_CYC)
    ) u_phase (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .start   (timer_start),
        .run     (timer_run),
        .tx_p    (tx_p),
        .tx_n    (tx_n),
        .wrap_c  (wrap_c)
    );

    // Next state, counters and timer control; any exit to IDLE drops the timer.
    always_comb begin
        state_nxt   = state;
        pulse_nxt   = pulse_idx;
        blank_nxt   = '0;
        timer_start = 1'b0;
        timer_run   = 1'b0;
        case (state)
            IDLE: begin
                pulse_nxt = '0;
                if (enTx) begin
                    state_nxt   = DRIVE;
                    timer_start = 1'b1;
                end
            end
            DRIVE: begin
                if (!enTx) begin
                    state_nxt = IDLE;
                    pulse_nxt = '0;
                end else if (wrap_c) begin
                    pulse_nxt = pulse_idx + IDX_W'(1);
                    if (last_pulse_c) begin
                        state_nxt = BLANK;
                    end else begin
                        timer_run = 1'b1;
                    end
                end else begin
                    timer_run = 1'b1;
                end
            end
            BLANK: begin
                if (!enTx) begin
                    state_nxt = IDLE;
                    pulse_nxt = '0;
                end else if (blank_cnt == BW'(BLANK_CYC - 1)) begin
                    state_nxt = DONE;
                end else begin
                    blank_nxt = blank_cnt + BW'(1);
                end
            end
            DONE: begin
                if (!enTx) begin
                    state_nxt = IDLE;
                    pulse_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                pulse_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state     <= IDLE;
            pulse_idx <= '0;
            blank_cnt <= '0;
            busy      <= 1'b0;
            overTx    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pulse_idx <= pulse_nxt;
            blank_cnt <= blank_nxt;
            busy      <= (state_nxt == DRIVE) || (state_nxt == BLANK);
            overTx    <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_tx_burst_gen.sv
// Bench for tx_burst_gen: small-parameter scoreboard runs plus a default-parameter dead-time run.
module tb_tx_burst_gen;

    localparam int unsigned HP     = 4;
    localparam int unsigned DC     = 1;
    localparam int unsigned PN     = 2;
    localparam int unsigned BC     = 3;
    localparam int unsigned PW     = $clog2(PN + 1);
    localparam int unsigned BURST  = 2 * HP * PN;
    localparam int          D_DEAD  = 10;
    localparam int          D_TOTAL = 2 * 1250 * 8 + 5000;

    typedef logic [PW+3:0] obs_t;
    typedef struct {
        int unsigned off;
        logic [3:0]  exp;   // {tx_p, tx_n, busy, overTx}
    } vec_t;

    logic          clk_100 = 1'b0;
    logic          rst_n;
    logic          enTx;
    logic          overTx, tx_p, tx_n, busy;
    logic [PW-1:0] pulse_idx;
    logic          en_d;
    logic          overTx_d, tx_p_d, tx_n_d, busy_d;
    logic [3:0]    pidx_d;

    int   n_vec = 0;
    int   n_err = 0;
    obs_t exp_q[$];
    int   m_st = 0;
    int   m_t  = 0;
    logic [3:0] rec [0:20];
    obs_t last_obs;
    vec_t vt [16];

    always #5 clk_100 = ~clk_100;

    tx_burst_gen #(
        .HALF_PERIOD (HP),
        .DEAD_CYC    (DC),
        .PULSE_NUM   (PN),
        .BLANK_CYC   (BC)
    ) dut (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .enTx      (enTx),
        .overTx    (overTx),
        .tx_p      (tx_p),
        .tx_n      (tx_n),
        .busy      (busy),
        .pulse_idx (pulse_idx)
    );

    tx_burst_gen dut_def (
        .clk_100   (clk_100),
        .rst_n     (rst_n),
        .enTx      (en_d),
        .overTx    (overTx_d),
        .tx_p      (tx_p_d),
        .tx_n      (tx_n_d),
        .busy      (busy_d),
        .pulse_idx (pidx_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: elapsed-time count since e0 drives all expectations.
    function automatic obs_t model_step(input logic r, input logic e);
        logic p, n, b, o;
        int   pi, ph;
        if (!r) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (e) begin m_st = 1; m_t = 0; end
                1: if (!e) m_st = 0;
                   else begin
                       m_t++;
                       if (m_t == int'(BURST + BC)) m_st = 2;
                   end
                default: if (!e) m_st = 0;
            endcase
        end
        p = 1'b0; n = 1'b0; b = 1'b0; o = 1'b0; pi = 0;
        if (m_st == 1) begin
            b = 1'b1;
            if (m_t < int'(BURST)) begin
                ph = m_t % int'(2 * HP);
                p  = (ph < int'(HP - DC));
                n  = (ph >= int'(HP)) && (ph < int'(2 * HP - DC));
                pi = m_t / int'(2 * HP);
            end else begin
                pi = int'(PN);
            end
        end else if (m_st == 2) begin
            o  = 1'b1;
            pi = int'(PN);
        end
        return {p, n, b, o, PW'(pi)};
    endfunction

    task automatic step(input logic r, input logic e);
        obs_t act, exp;
        rst_n = r;
        enTx  = e;
        exp_q.push_back(model_step(r, e));
        @(posedge clk_100);
        #1;
        act = {tx_p, tx_n, busy, overTx, pulse_idx};
        exp = exp_q.pop_front();
        check("cycle", 32'(act), 32'(exp));
        last_obs = act;
    endtask

    task automatic run_logged();
        for (int i = 0; i < 21; i++) begin
            step(1'b1, 1'b1);
            rec[i] = last_obs[PW+3:PW];
        end
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            check(tag, 32'(rec[vt[i].off]), 32'(vt[i].exp));
        end
    endtask

    // Overlap and dead-time watch on both instances.
    int   cyc_d  = 0;
    int   last_p = -1;
    int   last_n = -1;
    logic prev_p = 1'b0;
    logic prev_n = 1'b0;

    always @(negedge clk_100) begin
        int gap;
        cyc_d++;
        if (tx_p | tx_n) check("overlap", 32'(tx_p & tx_n), 32'(0));
        if (tx_p_d | tx_n_d) check("def_overlap", 32'(tx_p_d & tx_n_d), 32'(0));
        if (tx_p_d && !prev_p && last_n >= 0) begin
            gap = cyc_d - last_n - 1;
            check("def_dead_n2p", 32'((gap < D_DEAD) ? gap : D_DEAD), 32'(D_DEAD));
        end
        if (tx_n_d && !prev_n && last_p >= 0) begin
            gap = cyc_d - last_p - 1;
            check("def_dead_p2n", 32'((gap < D_DEAD) ? gap : D_DEAD), 32'(D_DEAD));
        end
        if (tx_p_d) last_p = cyc_d;
        if (tx_n_d) last_n = cyc_d;
        prev_p = tx_p_d;
        prev_n = tx_n_d;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vt[0]  = '{0,  4'b1010};  vt[1]  = '{2,  4'b1010};
        vt[2]  = '{3,  4'b0010};  vt[3]  = '{4,  4'b0110};
        vt[4]  = '{6,  4'b0110};  vt[5]  = '{7,  4'b0010};
        vt[6]  = '{8,  4'b1010};  vt[7]  = '{10, 4'b1010};
        vt[8]  = '{11, 4'b0010};  vt[9]  = '{12, 4'b0110};
        vt[10] = '{14, 4'b0110};  vt[11] = '{15, 4'b0010};
        vt[12] = '{16, 4'b0010};  vt[13] = '{18, 4'b0010};
        vt[14] = '{19, 4'b0001};  vt[15] = '{20, 4'b0001};

        rst_n = 1'b0;
        enTx  = 1'b0;
        en_d  = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("reset_state", 32'({tx_p, tx_n, busy, overTx, pulse_idx,
                                  tx_p_d, tx_n_d, busy_d, overTx_d, pidx_d}), 32'(0));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Nominal burst, then handshake
        run_logged();
        check_table("nominal");
        step(1'b1, 1'b0);
        check("handshake_over_clr", 32'(overTx), 32'(0));
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        run_logged();
        check_table("rerun");
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Abort in DRIVE at e0+5
        repeat (5) step(1'b1, 1'b1);
        check("abort_drive_txn_pre", 32'(tx_n), 32'(1));
        step(1'b1, 1'b0);
        check("abort_drive_txn", 32'(tx_n), 32'(0));
        check("abort_drive_busy", 32'(busy), 32'(0));
        repeat (30) step(1'b1, 1'b0);

        // Abort in BLANK at e0+17
        repeat (17) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("abort_blank_busy", 32'(busy), 32'(0));
        check("abort_blank_over", 32'(overTx), 32'(0));
        step(1'b1, 1'b1);
        check("abort_blank_restart", 32'(tx_p), 32'(1));
        step(1'b1, 1'b0);
        repeat (10) step(1'b1, 1'b0);

        // Reset mid-burst at e0+9, enTx held high
        repeat (9) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("reset_mid_burst", 32'({tx_p, tx_n, busy, overTx, pulse_idx}), 32'(0));
        run_logged();
        check_table("after_reset");
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // Default-parameter full burst
        en_d = 1'b1;
        k = 0;
        while (!overTx_d && k < D_TOTAL + 100) begin
            @(posedge clk_100);
            #1;
            k++;
        end
        check("def_over_edge", 32'(k - 1), 32'(D_TOTAL));
        check("def_busy_fall", 32'(busy_d), 32'(0));
        en_d = 1'b0;
        @(posedge clk_100);
        #1;
        check("def_over_clr", 32'(overTx_d), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
